// File: rtl/add_signed_rr_arbiter.sv
// add_signed_rr_arbiter: round-robin shares one signed adder among N requesters.
// The result sits in a one-entry output register with valid/ready handshake.
module add_signed_rr_arbiter #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [N*W-1:0]    a_flat,
  input  logic [N*W-1:0]    b_flat,
  output logic [N-1:0]      gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W:0]        out_sum,
  output logic [IDW-1:0]    out_id,
  output logic [CNTW-1:0]   op_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t          state_q, state_d;
  logic [W:0]      sum_q, sum_d;
  logic [IDW-1:0]  id_q, id_d, ptr_q, ptr_d, win;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            can_accept, acc, found;
  logic [W-1:0]    a_g, b_g;
  logic [W:0]      o;
  int              idx;
  // rst_n gates the grant so nothing is accepted while reset is held
  assign can_accept = rst_n && (state_q == EMPTY || out_ready);
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (can_accept && req[idx] && !found) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = IDW'(idx);
      end
    end
  end
  always_comb begin
    acc     = |gnt;
    a_g     = a_flat[win*W +: W];
    b_g     = b_flat[win*W +: W];
    o       = {a_g[W-1], a_g} + {b_g[W-1], b_g};
    sum_d   = acc ? o : sum_q;
    id_d    = acc ? win : id_q;
    ptr_d   = acc ? ((win == IDW'(N-1)) ? '0 : win + 1'b1) : ptr_q;
    cnt_d   = (acc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    state_d = acc ? FULL : (out_ready ? EMPTY : state_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      sum_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign out_valid = (state_q == FULL);
  assign out_sum   = sum_q;
  assign out_id    = id_q;
  assign op_cnt    = cnt_q;
endmodule

// File: tb/tb_add_signed_rr_arbiter.sv
// tb_add_signed_rr_arbiter: directed bench with a result scoreboard for add_signed_rr_arbiter.
module tb_add_signed_rr_arbiter;
  localparam int W = 8, N = 4, IDW = 2;
  logic clk = 1'b0, rst_n;
  logic [N-1:0] req, gnt;
  logic [N*W-1:0] a_flat, b_flat;
  logic out_valid, out_ready;
  logic [W:0] out_sum;
  logic [IDW-1:0] out_id;
  logic [15:0] op_cnt;
  logic [N-1:0] s_req, s_gnt;
  logic [N*W-1:0] s_zero = '0;
  logic s_ready = 1'b1, s_valid;
  logic [W:0] s_sum;
  logic [IDW-1:0] s_id;
  logic [3:0] s_cnt;
  typedef struct {int id; int sum;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int sums[N];

  always #5 clk = ~clk;

  add_signed_rr_arbiter #(.W(W), .N(N), .IDW(IDW), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_id(out_id), .op_cnt(op_cnt));

  add_signed_rr_arbiter #(.W(W), .N(N), .IDW(IDW), .CNTW(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .req(s_req), .a_flat(s_zero), .b_flat(s_zero),
    .gnt(s_gnt), .out_valid(s_valid), .out_ready(s_ready), .out_sum(s_sum),
    .out_id(s_id), .op_cnt(s_cnt));

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int i, input int a, input int b);
    a_flat[i*W +: W] = W'(a);
    b_flat[i*W +: W] = W'(b);
  endtask

  // Scoreboard: every consumed result must match the oldest expected one
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("q_underflow", q.size(), 1);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_id", int'(out_id), e.id);
        chk("sb_sum", int'($signed(out_sum)), e.sum);
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; out_ready = 1'b1; a_flat = '0; b_flat = '0; s_req = '0;
    repeat (2) @(posedge clk);
    #1 req = 4'b1111;
    @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_id", int'(out_id), 0);
    chk("rst_cnt", int'(op_cnt), 0);
    req = '0;
    tick();
    rst_n = 1'b1;
    // single operation with negative extremes
    req = 4'b0001; op(0, -127, -128); q.push_back('{0, -255});
    @(negedge clk);
    chk("t1_gnt", int'(gnt), 1);
    tick();
    req = '0;
    @(negedge clk);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_sum", int'($signed(out_sum)), -255);
    chk("t1_id", int'(out_id), 0);
    chk("t1_cnt", int'(op_cnt), 1);
    tick();
    @(negedge clk);
    chk("t1_drain", int'(out_valid), 0);
    // all requesting after a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      op(i, 10*i + 1, -3*i);
      sums[i] = 10*i + 1 - 3*i;
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      q.push_back('{k % N, sums[k % N]});
      @(negedge clk);
      chk("t2_gnt", int'(gnt), 1 << (k % N));
      if (k > 0) begin
        chk("t2_valid", int'(out_valid), 1);
        chk("t2_id", int'(out_id), (k - 1) % N);
      end
    end
    tick();
    req = '0;
    @(negedge clk);
    chk("t2_last_id", int'(out_id), 0);
    chk("t2_cnt", int'(op_cnt), 5);
    tick();
    // back-pressure
    req = 4'b0001; op(0, 100, 27); q.push_back('{0, 127});
    @(negedge clk);
    chk("t3_gnt0", int'(gnt), 1);
    tick();
    req = 4'b0110; out_ready = 1'b0; op(1, 5, 6); op(2, -50, -60);
    repeat (5) begin
      @(negedge clk);
      chk("t3_stall_gnt", int'(gnt), 0);
      chk("t3_stall_valid", int'(out_valid), 1);
      chk("t3_stall_sum", int'($signed(out_sum)), 127);
      tick();
    end
    out_ready = 1'b1; q.push_back('{1, 11});
    @(negedge clk);
    chk("t3_gnt1", int'(gnt), 4'b0010);
    tick();
    req = 4'b0100; q.push_back('{2, -110});
    @(negedge clk);
    chk("t3_gnt2", int'(gnt), 4'b0100);
    chk("t3_id1", int'(out_id), 1);
    tick();
    req = '0;
    @(negedge clk);
    chk("t3_id2", int'(out_id), 2);
    tick();
    // sweep through requester 2
    req = 4'b0100;
    for (int a = -127; a <= 127; a++) begin
      for (int b = -127; b <= 127; b += 2) begin
        op(2, a, b); q.push_back('{2, a + b});
        @(negedge clk);
        chk("t4_gnt", int'(gnt), 4'b0100);
        tick();
      end
    end
    op(2, -128, -128); q.push_back('{2, -256});
    tick();
    op(2, 127, -128); q.push_back('{2, -1});
    tick();
    req = '0;
    repeat (2) tick();
    chk("t4_q_empty", q.size(), 0);
    // asynchronous reset while full and stalled
    req = 4'b1000; op(3, 1, 2); q.push_back('{3, 3});
    @(negedge clk);
    chk("t5_gnt_pre", int'(gnt), 4'b1000);
    tick();
    req = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("t5_full", int'(out_valid), 1);
    #2 rst_n = 1'b0; req = 4'b1000;
    #1;
    chk("t5_rst_valid", int'(out_valid), 0);
    chk("t5_rst_cnt", int'(op_cnt), 0);
    chk("t5_rst_gnt", int'(gnt), 0);
    q.delete();
    tick();
    rst_n = 1'b1; out_ready = 1'b1; q.push_back('{3, 3});
    @(negedge clk);
    chk("t5_gnt_post", int'(gnt), 4'b1000);
    tick();
    req = '0;
    tick();
    // counter saturation on the 4-bit instance
    s_req = 4'b0001;
    repeat (20) tick();
    @(negedge clk);
    chk("t6_sat", int'(s_cnt), 15);
    tick();
    @(negedge clk);
    chk("t6_hold", int'(s_cnt), 15);
    s_req = '0;
    tick();
    chk("final_q_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
